// File: rtl/ram_arb_pkg.sv
// Shared types and RAM command opcodes for the two-port RAM arbiter.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      DATA  = 2'd2,
      RWAIT = 2'd3
   } state_t;

   localparam logic [1:0] OP_SET_WADDR = 2'b00;
   localparam logic [1:0] OP_WRITE     = 2'b01;
   localparam logic [1:0] OP_SET_RADDR = 2'b10;
   localparam logic [1:0] OP_READ      = 2'b11;

   function automatic logic [9:0] ram_cmd(input logic [1:0] op, input logic [7:0] payload);
      return {op, payload};
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: one-hot grant, pointer moves only on an accepted grant.
module rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] grant_o
);

   // 1 = requester 1 was granted last, so requester 0 wins the next tie
   logic last1_q;

   always_comb begin
      grant_o = '0;
      if (req_i == 2'b11) begin
         grant_o = last1_q ? 2'b01 : 2'b10;
      end else begin
         grant_o = req_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         last1_q <= 1'b1;
      end else if (accept_i) begin
         last1_q <= grant_o[1];
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a command-word RAM port.
// Optional RAM_ARB_ADDR_CACHE_EN skips the address beat when the address is already set.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,

   input  logic                 req0_valid,
   input  logic                 req0_wr,
   input  logic [ADDR_SIZE-1:0] req0_addr,
   input  logic [7:0]           req0_wdata,
   output logic                 req0_ready,
   output logic                 rsp0_valid,
   output logic [7:0]           rsp0_rdata,

   input  logic                 req1_valid,
   input  logic                 req1_wr,
   input  logic [ADDR_SIZE-1:0] req1_addr,
   input  logic [7:0]           req1_wdata,
   output logic                 req1_ready,
   output logic                 rsp1_valid,
   output logic [7:0]           rsp1_rdata,

   output logic [9:0]           ram_din,
   output logic                 ram_rx_valid,
   input  logic [7:0]           ram_dout,
   input  logic                 ram_tx_valid
);

   state_t                 state_q, state_d;
   logic                   wr_q;
   logic [ADDR_SIZE-1:0]   addr_q;
   logic [7:0]             wdata_q;
   logic                   id_q;
   logic                   rsp0_valid_q, rsp1_valid_q;
   logic [7:0]             rsp0_rdata_q, rsp1_rdata_q;

   logic [1:0]             req_vec;
   logic [1:0]             grant;
   logic                   accept;
   logic                   sel_wr;
   logic [ADDR_SIZE-1:0]   sel_addr;
   logic [7:0]             sel_wdata;
   logic                   cache_hit;
   logic [7:0]             addr_byte;

   // Requests are only visible to the arbiter while idle and out of reset
   assign req_vec = (rst_n && (state_q == IDLE)) ? {req1_valid, req0_valid} : 2'b00;

   rr_arb2 u_rr_arb2 (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .req_i    (req_vec),
      .accept_i (accept),
      .grant_o  (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign accept     = |grant;

   assign sel_wr    = grant[1] ? req1_wr    : req0_wr;
   assign sel_addr  = grant[1] ? req1_addr  : req0_addr;
   assign sel_wdata = grant[1] ? req1_wdata : req0_wdata;
   assign addr_byte = 8'(addr_q);

`ifdef RAM_ARB_ADDR_CACHE_EN
   logic                 wc_valid_q, rc_valid_q;
   logic [ADDR_SIZE-1:0] wc_addr_q, rc_addr_q;

   // Track the address most recently sent in an ADDR beat, per direction
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wc_valid_q <= 1'b0;
         rc_valid_q <= 1'b0;
         wc_addr_q  <= '0;
         rc_addr_q  <= '0;
      end else if (state_q == ADDR) begin
         if (wr_q) begin
            wc_valid_q <= 1'b1;
            wc_addr_q  <= addr_q;
         end else begin
            rc_valid_q <= 1'b1;
            rc_addr_q  <= addr_q;
         end
      end
   end

   assign cache_hit = sel_wr ? (wc_valid_q && (wc_addr_q == sel_addr))
                             : (rc_valid_q && (rc_addr_q == sel_addr));
`else
   assign cache_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = cache_hit ? DATA : ADDR;
         ADDR:    state_d = DATA;
         DATA:    state_d = wr_q ? IDLE : RWAIT;
         RWAIT:   if (ram_tx_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ram_din      = '0;
      ram_rx_valid = 1'b0;
      case (state_q)
         ADDR: begin
            ram_rx_valid = 1'b1;
            ram_din      = ram_cmd(wr_q ? OP_SET_WADDR : OP_SET_RADDR, addr_byte);
         end
         DATA: begin
            ram_rx_valid = 1'b1;
            ram_din      = ram_cmd(wr_q ? OP_WRITE : OP_READ, wr_q ? wdata_q : 8'h00);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         id_q         <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         if (accept) begin
            wr_q    <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            id_q    <= grant[1];
         end
         if ((state_q == RWAIT) && ram_tx_valid) begin
            if (id_q) begin
               rsp1_valid_q <= 1'b1;
               rsp1_rdata_q <= ram_dout;
            end else begin
               rsp0_valid_q <= 1'b1;
               rsp0_rdata_q <= ram_dout;
            end
         end
      end
   end

   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_rdata = rsp0_rdata_q;
   assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter with a behavioural command-word RAM.
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req0_wr = 1'b0;
   logic [7:0] req0_addr = '0, req0_wdata = '0;
   logic       req1_valid = 1'b0, req1_wr = 1'b0;
   logic [7:0] req1_addr = '0, req1_wdata = '0;
   logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [7:0] rsp0_rdata, rsp1_rdata;
   logic [9:0] ram_din;
   logic       ram_rx_valid;
   logic [7:0] ram_dout = '0;
   logic       ram_tx_valid = 1'b0;

   int checks = 0;
   int failures = 0;

   ram_arbiter #(.ADDR_SIZE(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
      .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: read data appears rd_delay cycles after the cycle following the read beat
   logic [7:0]  mem [256];
   logic [7:0]  m_waddr = '0, m_raddr = '0;
   logic        rd_pend = 1'b0;
   int unsigned rd_cnt = 0;
   int unsigned rd_delay = 0;

   always @(posedge clk) begin
      ram_tx_valid <= 1'b0;
      if (rd_pend) begin
         if (rd_cnt == 0) begin
            ram_tx_valid <= 1'b1;
            ram_dout     <= mem[m_raddr];
            rd_pend      <= 1'b0;
         end else begin
            rd_cnt <= rd_cnt - 1;
         end
      end
      if (ram_rx_valid) begin
         case (ram_din[9:8])
            2'b00: m_waddr <= ram_din[7:0];
            2'b01: mem[m_waddr] <= ram_din[7:0];
            2'b10: m_raddr <= ram_din[7:0];
            default: begin
               if (rd_delay == 0) begin
                  ram_tx_valid <= 1'b1;
                  ram_dout     <= mem[m_raddr];
               end else begin
                  rd_pend <= 1'b1;
                  rd_cnt  <= rd_delay - 1;
               end
            end
         endcase
      end
   end

   typedef struct {
      bit          id;
      bit          wr;
      logic [7:0]  addr;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
      int unsigned delay;
   } vec_t;

   vec_t vecs [9];

   // Expected-side address cache state and last read data per requester
   logic       c_wv = 1'b0, c_rv = 1'b0;
   logic [7:0] c_wa = '0, c_ra = '0;
   logic [7:0] last_rd [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic ready_of(input bit id);
      return id ? req1_ready : req0_ready;
   endfunction

   function automatic logic rspv_of(input bit id);
      return id ? rsp1_valid : rsp0_valid;
   endfunction

   function automatic logic [7:0] rdata_of(input bit id);
      return id ? rsp1_rdata : rsp0_rdata;
   endfunction

   task automatic drive(input bit id, input logic v, input logic wr, input logic [7:0] a, input logic [7:0] d);
      if (id) begin
         req1_valid = v; req1_wr = wr; req1_addr = a; req1_wdata = d;
      end else begin
         req0_valid = v; req0_wr = wr; req0_addr = a; req0_wdata = d;
      end
   endtask

   task automatic probe_ready(input string name, input bit id, input logic exp);
      if (id) req1_valid = 1'b1; else req0_valid = 1'b1;
      #1;
      chk(name, ready_of(id), exp);
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   function automatic bit cache_hit(input bit wr, input logic [7:0] a);
`ifdef RAM_ARB_ADDR_CACHE_EN
      return wr ? (c_wv && c_wa == a) : (c_rv && c_ra == a);
`else
      return 1'b0;
`endif
   endfunction

   task automatic do_reset(input bit with_checks);
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 0, 0, 8'h00, 8'h00);
      drive(1, 0, 0, 8'h00, 8'h00);
      repeat (2) @(negedge clk);
      if (with_checks) begin
         chk("rst_rx_valid", ram_rx_valid, 1'b0);
         chk("rst_din", ram_din, 10'h000);
         chk("rst_rsp0_valid", rsp0_valid, 1'b0);
         chk("rst_rsp1_valid", rsp1_valid, 1'b0);
         chk("rst_rsp0_rdata", rsp0_rdata, 8'h00);
         chk("rst_rsp1_rdata", rsp1_rdata, 8'h00);
         probe_ready("rst_ready0", 0, 1'b0);
      end
      rst_n = 1'b1;
      c_wv = 1'b0; c_rv = 1'b0;
      last_rd[0] = 8'h00; last_rd[1] = 8'h00;
   endtask

   task automatic run_txn(input int idx, input vec_t v);
      bit hit;
      int n;
      string p;
      p = $sformatf("v%0d", idx);
      hit = cache_hit(v.wr, v.addr);
      if (!hit) begin
         if (v.wr) begin c_wv = 1'b1; c_wa = v.addr; end
         else      begin c_rv = 1'b1; c_ra = v.addr; end
      end
      rd_delay = v.delay;
      @(negedge clk);
      drive(v.id, 1, v.wr, v.addr, v.wdata);
      #1;
      n = 0;
      while (!ready_of(v.id) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk({p, "_ready"}, ready_of(v.id), 1'b1);
      @(posedge clk);
      @(negedge clk);
      // Scramble the request after acceptance; the latched copy must be used
      drive(v.id, 0, ~v.wr, ~v.addr, ~v.wdata);
      if (!hit) begin
         chk({p, "_addr_rx"}, ram_rx_valid, 1'b1);
         chk({p, "_addr_din"}, ram_din, {v.wr ? 2'b00 : 2'b10, v.addr});
         probe_ready({p, "_busy_ready"}, v.id, 1'b0);
         @(negedge clk);
      end
      chk({p, "_data_rx"}, ram_rx_valid, 1'b1);
      chk({p, "_data_din"}, ram_din, v.wr ? {2'b01, v.wdata} : 10'h300);
      @(negedge clk);
      if (v.wr) begin
         chk({p, "_done_rx"}, ram_rx_valid, 1'b0);
         chk({p, "_done_rsp"}, {rsp1_valid, rsp0_valid}, 2'b00);
         probe_ready({p, "_idle_ready"}, v.id, 1'b1);
      end else begin
         for (int unsigned d = 0; d <= v.delay; d++) begin
            chk({p, "_wait_rx"}, ram_rx_valid, 1'b0);
            chk({p, "_wait_rsp"}, {rsp1_valid, rsp0_valid}, 2'b00);
            @(negedge clk);
         end
         chk({p, "_rsp_valid"}, rspv_of(v.id), 1'b1);
         chk({p, "_rsp_rdata"}, rdata_of(v.id), v.rdata);
         chk({p, "_other_valid"}, rspv_of(!v.id), 1'b0);
         chk({p, "_other_rdata"}, rdata_of(!v.id), last_rd[!v.id]);
         last_rd[v.id] = v.rdata;
         probe_ready({p, "_idle_ready"}, v.id, 1'b1);
         @(negedge clk);
         chk({p, "_rsp_pulse"}, rspv_of(v.id), 1'b0);
      end
   endtask

   initial begin
      int g;
      int cyc;
      bit hit;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      vecs[0] = '{1'b0, 1'b1, 8'h3C, 8'hA5, 8'h00, 0};
      vecs[1] = '{1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5, 0};
      vecs[2] = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, 0};
      vecs[3] = '{1'b1, 1'b1, 8'h10, 8'h5A, 8'h00, 0};
      vecs[4] = '{1'b1, 1'b1, 8'h10, 8'h66, 8'h00, 0};
      vecs[5] = '{1'b0, 1'b1, 8'h11, 8'h77, 8'h00, 0};
      vecs[6] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h66, 0};
      vecs[7] = '{1'b1, 1'b0, 8'h11, 8'h00, 8'h77, 2};
      vecs[8] = '{1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1};

      do_reset(1);

      // Tie after reset: requester 0 first, then strict alternation while both stay valid
      @(negedge clk);
      drive(0, 1, 1, 8'h20, 8'h11);
      drive(1, 1, 1, 8'h21, 8'h22);
      g = 0;
      cyc = 0;
      while (g < 4 && cyc < 60) begin
         #1;
         if (req0_ready || req1_ready) begin
            chk($sformatf("tie_grant%0d", g), {req1_ready, req0_ready}, (g % 2 == 0) ? 2'b01 : 2'b10);
            g++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("tie_grant_count", g, 4);
      drive(0, 0, 0, 8'h00, 8'h00);
      drive(1, 0, 0, 8'h00, 8'h00);
      repeat (6) @(negedge clk);

      do_reset(0);
      foreach (vecs[i]) run_txn(i, vecs[i]);

      // Reset while the read command beat is on the bus
      rd_delay = 0;
      hit = cache_hit(1'b0, 8'h3C);
      @(negedge clk);
      drive(0, 1, 0, 8'h3C, 8'h00);
      #1;
      cyc = 0;
      while (!req0_ready && cyc < 20) begin
         @(negedge clk); #1; cyc++;
      end
      chk("mr_ready", req0_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(0, 0, 0, 8'h00, 8'h00);
      if (!hit) @(negedge clk);
      chk("mr_data_din", ram_din, 10'h300);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mr_rx_valid", ram_rx_valid, 1'b0);
      chk("mr_din", ram_din, 10'h000);
      chk("mr_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      chk("mr_rdata0", rsp0_rdata, 8'h00);
      rst_n = 1'b1;
      c_wv = 1'b0; c_rv = 1'b0;
      @(negedge clk);
      chk("mr_rsp_after", {rsp1_valid, rsp0_valid}, 2'b00);
      probe_ready("mr_idle_ready", 0, 1'b1);
      @(negedge clk);
      chk("mr_rsp_late", {rsp1_valid, rsp0_valid}, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
